// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC, two-cycle memory pipeline tracking, instruction buffer, redirect flush.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_read_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_q,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic             s0_vld_q, s0_vld_d;
    logic [31:0]      s0_pc_q;
    logic             s1_vld_q, s1_vld_d;
    logic [31:0]      s1_pc_q;
    logic [31:0]      fifo_instr_q [FIFO_DEPTH];
    logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [CNT_W:0]   occupancy;
    logic             issue;
    logic             push;
    logic             pop;

    // Credit: buffered plus in-flight words may never exceed the buffer size,
    // so every returning word is guaranteed a slot.
    assign occupancy = {1'b0, count_q} + (CNT_W + 1)'(s0_vld_q) + (CNT_W + 1)'(s1_vld_q);
    assign issue     = rst_n && !redirect && (occupancy < DEPTH_OCC);
    assign push      = s1_vld_q && !redirect;
    assign pop       = instr_valid && !stall && !redirect;

    assign imem_read_en = issue;
    assign imem_addr    = issue ? pc_q : 32'h0;
    assign instr_valid  = (count_q != '0);
    assign instr        = fifo_instr_q[rd_ptr_q];
    assign instr_pc     = fifo_pc_q[rd_ptr_q];

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        s0_vld_d = issue;
        s1_vld_d = s0_vld_q && !redirect;
        if (redirect) begin
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d = pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            s0_vld_q <= 1'b0;
            s0_pc_q  <= 32'h0;
            s1_vld_q <= 1'b0;
            s1_pc_q  <= 32'h0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            s0_vld_q <= s0_vld_d;
            s0_pc_q  <= pc_q;
            s1_vld_q <= s1_vld_d;
            s1_pc_q  <= s0_pc_q;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head outputs read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= 32'h0;
                fifo_pc_q[i]    <= 32'h0;
            end
        end else if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_q;
            fifo_pc_q[wr_ptr_q]    <= s1_pc_q;
        end
    end

    overflow_never: assert property (@(posedge clk) disable iff (!rst_n)
        (push && !pop) |-> (count_q != DEPTH_CNT));

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;

    always_comb begin
        perf_fetched_d  = perf_fetched_q;
        perf_squashed_d = perf_squashed_q;
        if (pop) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (redirect) begin
            perf_squashed_d = perf_squashed_q + 32'(occupancy);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q  <= 32'h0;
            perf_squashed_q <= 32'h0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: bench-side two-cycle memory, transaction scoreboard of issued fetches,
// directed phases (steady stream, stall fill, redirect, wrap, async reset) followed by random traffic.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_read_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_q;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_read_en (imem_read_en),
        .imem_addr    (imem_addr),
        .imem_q       (imem_q),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_squashed(perf_squashed)
`endif
    );

    typedef struct packed {
        int          t;
        logic [31:0] pc;
    } fetch_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    fetch_t      outst[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_fetched;
    logic [31:0] exp_squashed;
    logic        rc_v, r1_v, r2_v;
    logic [31:0] rc_a, r1_a, r2_a;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h100 + {2'b00, a[31:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %08h expected %08h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        outst.delete();
        exp_pc       = RESET_PC;
        exp_fetched  = 32'h0;
        exp_squashed = 32'h0;
    endtask

    task automatic check_zero();
        chk("rst_read_en", 32'(imem_read_en), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched, 32'h0);
        chk("rst_perf_squashed", perf_squashed, 32'h0);
`endif
    endtask

    // Memory answers a request sampled at the end of cycle k during cycle k+2.
    task automatic mem_shift();
        r2_v = r1_v;
        r2_a = r1_a;
        r1_v = rc_v;
        r1_a = rc_a;
        imem_q = r2_v ? memf(r2_a) : $urandom;
    endtask

    task automatic evaluate();
        int   occ;
        logic exp_rd;
        logic exp_v;
        if (!rst_n) begin
            check_zero();
        end else begin
            occ    = outst.size();
            exp_rd = !redirect && (occ < DEPTH);
            exp_v  = (occ > 0) && (outst[0].t + 3 <= cyc);
            chk("read_en", 32'(imem_read_en), 32'(exp_rd));
            if (exp_rd) chk("imem_addr", imem_addr, exp_pc);
            chk("instr_valid", 32'(instr_valid), 32'(exp_v));
            if (exp_v) begin
                chk("instr_pc", instr_pc, outst[0].pc);
                chk("instr", instr, memf(outst[0].pc));
            end
`ifdef FETCH_PERF_EN
            chk("perf_fetched", perf_fetched, exp_fetched);
            chk("perf_squashed", perf_squashed, exp_squashed);
`endif
            if (redirect) begin
                exp_squashed = exp_squashed + 32'(occ);
                outst.delete();
                exp_pc = redirect_pc;
            end else begin
                if (exp_v && !stall) begin
                    void'(outst.pop_front());
                    exp_fetched = exp_fetched + 32'd1;
                end
                if (exp_rd) begin
                    outst.push_back('{t: cyc, pc: exp_pc});
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        rc_v = imem_read_en;
        rc_a = imem_addr;
    endtask

    task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic rel);
        @(posedge clk);
        #1;
        cyc++;
        mem_shift();
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        if (rel) rst_n = 1'b1;
        @(negedge clk);
        evaluate();
    endtask

    task automatic rand_step();
        logic [31:0] rpc;
        rpc      = $urandom;
        rpc[1:0] = 2'b00;
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), rpc, 1'b0);
    endtask

    // Reset is dropped mid-cycle, away from any clock edge.
    task automatic async_reset();
        @(posedge clk);
        #1;
        cyc++;
        mem_shift();
        stall    = 1'b0;
        redirect = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero();
        model_reset();
        @(negedge clk);
        evaluate();
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_q      = 32'h0;
        rc_v = 1'b0; r1_v = 1'b0; r2_v = 1'b0;
        rc_a = 32'h0; r1_a = 32'h0; r2_a = 32'h0;
        model_reset();
        #2;
        check_zero();
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);

        step(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (11) step(1'b0, 1'b0, 32'h0, 1'b0);

        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0);

        step(1'b0, 1'b1, 32'h40, 1'b0);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0);

        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h200, 1'b0);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0);

        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0);

        repeat (300) rand_step();

        async_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0);

        repeat (100) rand_step();

        async_reset();
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch front end for the battleship processor core. Holds the PC, drives read requests into the two-cycle-latency instruction memory, and tracks returning words. Buffers returned words in a small FIFO so decode stalls never drop data. Handles branch redirects by squashing in-flight and buffered fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, default 4: instruction buffer entries; power of two, minimum 4.
- `clk` in 1: sole clock, all logic on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_read_en` out 1: memory read request this cycle.
- `imem_addr` out 32: byte address of the request, word aligned (bits [1:0] = 0).
- `imem_q` in 32: memory data, valid exactly 2 cycles after the request cycle.
- `stall` in 1: decode hazard; head instruction not consumed this cycle.
- `redirect` in 1: taken branch or jump; flush and restart fetch.
- `redirect_pc` in 32: new fetch address, sampled when `redirect`=1.
- `instr` out 32: instruction at the FIFO head.
- `instr_pc` out 32: PC of `instr`.
- `instr_valid` out 1: FIFO non-empty.
- `perf_fetched` out 32 (only with `FETCH_PERF_EN`): instructions delivered.
- `perf_squashed` out 32 (only with `FETCH_PERF_EN`): words discarded by redirect.

## Operation
- Registers:
  - `pc`: next address to issue.
  - 2-stage in-flight shift register: valid bit + PC per stage, s0 then s1.
  - FIFO: instr + PC per entry, with count.
- Issue:
  - Issue when `!redirect && (fifo_count + inflight_count) < FIFO_DEPTH`, using counts before this cycle's pop.
  - On issue: `imem_read_en`=1, `imem_addr`=`pc`; `pc` <= `pc`+4, wrapping mod 2^32.
  - The in-flight entry enters s0 and shifts s0→s1 every cycle unconditionally.
- Return: when s1 is valid, `imem_q` is captured into the FIFO with s1's PC. Space is guaranteed by the credit rule, so no overflow check is needed; an overflow is a bug.
- Consume: pop when `instr_valid && !stall && !redirect`.
- Outputs: `instr`/`instr_pc` come directly from the head entry registers. When the FIFO is empty they show the last-popped value and are don't-care.
- Redirect takes priority over everything:
  - `pc` <= `redirect_pc`.
  - FIFO is emptied.
  - s0/s1 valid bits are cleared, so in-flight returns are ignored.
  - No issue that cycle.
  - Next cycle issues `redirect_pc`.
- Simultaneous events:
  - Push and pop in the same cycle leave the count unchanged.
  - Redirect coinciding with a return discards the returned word.
  - Stall with a full FIFO stops issue; in-flight words still land.
- Reset: `pc`=`RESET_PC`, FIFO empty, in-flight valids 0.
  - Reset output values: `imem_read_en`=0, `imem_addr`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, perf counters 0.
  - Reset mid-operation discards everything; in-flight memory returns after release are ignored.

## Timing
- `imem_read_en`/`imem_addr` are driven combinationally from `pc`, counts and `redirect`. The memory samples them at the end of the issue cycle.
- Request issued in cycle k: `imem_q` valid in cycle k+2, captured at the end of k+2, `instr_valid` in cycle k+3.
- Issue-to-visible latency: 3 cycles. First `instr_valid` arrives 3 cycles after the first clock with `rst_n` high.
- Throughput: 1 instruction/cycle sustained with no stall (steady state holds 2 in flight plus 1 buffered, below depth 4).
- Redirect in cycle r: first issue of `redirect_pc` in r+1, valid at decode in r+4. Redirect penalty: 3 bubbles.
- Stall release: a buffered head is consumed in the same cycle `stall` drops.

## Configuration
- `FETCH_PERF_EN` defined:
  - `perf_fetched` increments on every pop.
  - `perf_squashed` adds the number of FIFO entries plus valid in-flight stages discarded on each redirect.
  - Both are 32-bit, wrap, and are reset to 0.
- `FETCH_PERF_EN` undefined: both ports and counters are absent; fetch behaviour is identical.

## Test plan
- Reset release, no stall, memory preloaded 0x100+n at word n:
  - `imem_addr` = 0,4,8,… one per cycle.
  - `instr_valid` first high in cycle 3, `instr`=0x100, `instr_pc`=0.
  - Then consecutive words every cycle.
- `stall` held 10 cycles after steady state:
  - FIFO fills to 4 and `imem_read_en` drops.
  - No word lost or duplicated.
  - On release, `instr` sequence continues in order with PCs +4.
- `redirect`=1 with `redirect_pc`=0x40 while 2 requests are in flight and 1 word is buffered:
  - Next cycle `imem_addr`=0x40.
  - `instr_valid` stays 0 for 3 cycles, then `instr_pc`=0x40.
  - `perf_squashed` increases by 3 when `FETCH_PERF_EN` is defined.
- Redirect and stall asserted together with a full FIFO: flush wins, FIFO is empty next cycle, and fetch restarts at `redirect_pc`.
- Start fetch at `redirect_pc`=0xFFFF_FFF8: addresses go 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, showing PC wrap.
- Assert `rst_n`=0 asynchronously mid-stream:
  - All outputs go 0 immediately.
  - After release, fetch restarts at `RESET_PC`; stale `imem_q` returns never appear on `instr`.
